// File: rtl/signed_bcd_formatter_if.sv
// Handshake and result bundle between a value producer and signed_bcd_formatter.
// master: requester (drives start/value, observes the result)
// slave : the formatter itself
interface signed_bcd_formatter_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             sign;
    logic [3:0]       digit1;
    logic [3:0]       digit2;
    logic             overflow;
    logic             lcd_disable;

    modport master (
        output start, value,
        input  busy, done, sign, digit1, digit2, overflow, lcd_disable
    );

    modport slave (
        input  start, value,
        output busy, done, sign, digit1, digit2, overflow, lcd_disable
    );
endinterface

// File: rtl/signed_bcd_formatter.sv
// signed_bcd_formatter: two's-complement value -> sign + two BCD digits for the
// 2-digit LCD driver, using one double-dabble step per clock.
// Outputs are only rewritten in DONE, so the display never shows a torn value.
// Optional build macro: DISPLAY_SATURATE_EN clamps the digits to 9,9 on overflow;
// without it the digits show |value| mod 100.
module signed_bcd_formatter #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_bcd_formatter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH+7:0] shift_q, shift_d;     // {bcd[7:0], mag[WIDTH-1:0]}
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_c_q, sign_c_d;
    logic             nz_c_q, nz_c_d;
    logic             ovf_c_q, ovf_c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sign_q, sign_d;
    logic [3:0]       digit1_q, digit1_d;
    logic [3:0]       digit2_q, digit2_d;
    logic             overflow_q, overflow_d;
    logic             lcd_disable_q, lcd_disable_d;

    logic [WIDTH-1:0] mag_v;
    logic [3:0]       tens_adj, ones_adj;

    // Next-state and next-output computation for the IDLE -> CONV -> DONE sequence.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        sign_c_d      = sign_c_q;
        nz_c_d        = nz_c_q;
        ovf_c_d       = ovf_c_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        sign_d        = sign_q;
        digit1_d      = digit1_q;
        digit2_d      = digit2_q;
        overflow_d    = overflow_q;
        lcd_disable_d = lcd_disable_q;

        // Negating the most negative value yields 2^(WIDTH-1), which still fits unsigned.
        mag_v    = bus.value[WIDTH-1] ? (~bus.value + 1'b1) : bus.value;
        tens_adj = shift_q[WIDTH+7:WIDTH+4];
        ones_adj = shift_q[WIDTH+3:WIDTH];
        if (tens_adj >= 4'd5) tens_adj = tens_adj + 4'd3;
        if (ones_adj >= 4'd5) ones_adj = ones_adj + 4'd3;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sign_c_d = bus.value[WIDTH-1];
                    nz_c_d   = |bus.value;
                    ovf_c_d  = 32'(mag_v) > 32'd99;
                    shift_d  = {8'h00, mag_v};
                    cnt_d    = CW'(WIDTH);
                    busy_d   = 1'b1;
                    state_d  = S_CONV;
                end
            end
            S_CONV: begin
                // Carry out of the tens nibble is dropped: digits end up as value mod 100.
                shift_d = {tens_adj, ones_adj, shift_q[WIDTH-1:0]} << 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                sign_d     = sign_c_q & nz_c_q;
                overflow_d = ovf_c_q;
`ifdef DISPLAY_SATURATE_EN
                if (ovf_c_q) begin
                    digit1_d = 4'd9;
                    digit2_d = 4'd9;
                end else begin
                    digit1_d = shift_q[WIDTH+7:WIDTH+4];
                    digit2_d = shift_q[WIDTH+3:WIDTH];
                end
`else
                digit1_d = shift_q[WIDTH+7:WIDTH+4];
                digit2_d = shift_q[WIDTH+3:WIDTH];
`endif
                done_d        = 1'b1;
                busy_d        = 1'b0;
                lcd_disable_d = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            sign_c_q      <= 1'b0;
            nz_c_q        <= 1'b0;
            ovf_c_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sign_q        <= 1'b0;
            digit1_q      <= 4'd0;
            digit2_q      <= 4'd0;
            overflow_q    <= 1'b0;
            lcd_disable_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            sign_c_q      <= sign_c_d;
            nz_c_q        <= nz_c_d;
            ovf_c_q       <= ovf_c_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sign_q        <= sign_d;
            digit1_q      <= digit1_d;
            digit2_q      <= digit2_d;
            overflow_q    <= overflow_d;
            lcd_disable_q <= lcd_disable_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.sign        = sign_q;
    assign bus.digit1      = digit1_q;
    assign bus.digit2      = digit2_q;
    assign bus.overflow    = overflow_q;
    assign bus.lcd_disable = lcd_disable_q;
endmodule

// File: tb/tb_signed_bcd_formatter.sv
// Self-checking bench for signed_bcd_formatter (WIDTH=8) against an arithmetic model.
module tb_signed_bcd_formatter;
    localparam int W = 8;
`ifdef DISPLAY_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    signed_bcd_formatter_if #(.WIDTH(W)) bus_if ();

    signed_bcd_formatter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference: {sign, digit1, digit2, overflow} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [W-1:0] raw);
        int v, m, d1, d2;
        logic s, o;
        v = int'($signed(raw));
        m = (v < 0) ? -v : v;
        s = (v < 0);
        o = (m > 99);
        d1 = (m / 10) % 10;
        d2 = m % 10;
        if (SAT && o) begin
            d1 = 9;
            d2 = 9;
        end
        return {s, 4'(d1), 4'(d2), o};
    endfunction

    function automatic logic [9:0] observed();
        return {bus_if.sign, bus_if.digit1, bus_if.digit2, bus_if.overflow};
    endfunction

    // Issue one accepted start and return the cycle of the done pulse (-1 on timeout).
    task automatic convert(input logic [W-1:0] v, output int lat);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.value = v;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus_if.busy, bus_if.done, observed(), bus_if.lcd_disable} !== {2'b00, 10'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b out=%h lcd_dis=%b, want 0 0 000 1",
                     bus_if.busy, bus_if.done, observed(), bus_if.lcd_disable);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] vals [5] = '{8'hDB, 8'h00, 8'd99, 8'd127, 8'h80};
        int lat;
        foreach (vals[i]) begin
            convert(vals[i], lat);
            n_checks++;
            if (lat !== 9) begin
                n_fail++;
                $display("FAIL directed_latency v=%h: got %0d want 9", vals[i], lat);
            end
            n_checks++;
            if (observed() !== model(vals[i])) begin
                n_fail++;
                $display("FAIL directed_result v=%h: got %h want %h", vals[i], observed(), model(vals[i]));
            end
            n_checks++;
            if (bus_if.lcd_disable !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_lcd_disable v=%h: got %b want 0", vals[i], bus_if.lcd_disable);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus_if.done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse_width v=%h: got %b want 0", vals[i], bus_if.done);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int ndone = 0;
        int first = -1;
        int lat;
        logic [9:0] snap = '0;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.value = 8'd5;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    snap = observed();
                end
            end
            if (k <= 12) begin
                n_checks++;
                if (bus_if.busy !== (k <= 8)) begin
                    n_fail++;
                    $display("FAIL busy_flag cycle %0d: got %b want %b", k, bus_if.busy, (k <= 8));
                end
            end
            if (k == 2) begin
                @(negedge clk);
                bus_if.start = 1'b1;
                bus_if.value = 8'hC0;
            end else if (k == 3) begin
                @(negedge clk);
                bus_if.start = 1'b0;
            end
        end
        n_checks++;
        if (ndone !== 1 || first !== 9) begin
            n_fail++;
            $display("FAIL ignore_start_done: got %0d pulses first at %0d, want 1 at 9", ndone, first);
        end
        n_checks++;
        if (snap !== model(8'd5)) begin
            n_fail++;
            $display("FAIL ignore_start_result: got %h want %h", snap, model(8'd5));
        end
        convert(8'hC0, lat);
        n_checks++;
        if (lat !== 9 || observed() !== model(8'hC0)) begin
            n_fail++;
            $display("FAIL after_ignore_convert: got lat=%0d out=%h want 9 %h", lat, observed(), model(8'hC0));
        end
    endtask

    task automatic test_reset_mid_conv();
        int ndone = 0;
        int lat;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.value = 8'd42;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus_if.busy, bus_if.done, observed(), bus_if.lcd_disable} !== {2'b00, 10'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL midconv_reset_state: got busy=%b done=%b out=%h lcd_dis=%b, want 0 0 000 1",
                     bus_if.busy, bus_if.done, observed(), bus_if.lcd_disable);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done || bus_if.busy) ndone++;
        end
        n_checks++;
        if (ndone !== 0 || observed() !== 10'd0 || bus_if.lcd_disable !== 1'b1) begin
            n_fail++;
            $display("FAIL midconv_no_done: got %0d active cycles out=%h lcd_dis=%b, want 0 000 1",
                     ndone, observed(), bus_if.lcd_disable);
        end
        convert(8'd42, lat);
        n_checks++;
        if (lat !== 9 || observed() !== model(8'd42)) begin
            n_fail++;
            $display("FAIL midconv_recover: got lat=%0d out=%h want 9 %h", lat, observed(), model(8'd42));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        int lat;
        for (int i = 0; i < 40; i++) begin
            v = W'($urandom_range(0, 255));
            convert(v, lat);
            n_checks++;
            if (lat !== 9 || observed() !== model(v)) begin
                n_fail++;
                $display("FAIL random v=%h: got lat=%0d out=%h want 9 %h", v, lat, observed(), model(v));
            end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] v;
        logic [9:0] expv;
        int lat;
        v = 8'hE7;
        convert(v, lat);
        expv = model(v);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus_if.value = W'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            n_checks++;
            if (observed() !== expv || bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle %0d: got out=%h done=%b busy=%b want %h 0 0",
                         k, observed(), bus_if.done, bus_if.busy, expv);
            end
        end
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.value = '0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid_conv();
        test_random();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
